// File: rtl/ram_axi_arbiter_pkg.sv
// Shared types and constants for the RAM AXI4-Lite arbiter.
package ram_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP
   } arb_state_t;

   localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/ram_axi_arbiter_if.sv
// AXI4-Lite master/slave bundle between the arbiter and the RAM.
interface ram_axi_arbiter_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB-1:0]       wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/ram_axi_arbiter_rr.sv
// Round-robin pick: first requester at or after ptr (wrapping); combinational, no backpressure.
module rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   always_comb begin
      int j;
      j     = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/ram_axi_arbiter.sv
// Round-robin share of one AXI4-Lite RAM; one transaction in flight, read grant->rsp in 4 cycles.
// req_ready only in IDLE (others held off); rsp_valid is a one-cycle pulse; ARB_PERF_EN adds perf counters.
module ram_axi_arbiter
   import ram_arb_pkg::*;
#(
   parameter  int ADDR_WIDTH = 10,
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_REQ    = 2,
   localparam int STRB       = DATA_WIDTH / 8,
   localparam int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                          axi_aclk,
   input  logic                          axi_areset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ*STRB-1:0]       req_wstrb,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_err,
`ifdef ARB_PERF_EN
   output logic [NUM_REQ*32-1:0]         perf_grants,
   output logic [NUM_REQ*32-1:0]         perf_wait,
`endif
   ram_axi_arbiter_if.master             m_axi
);

   arb_state_t           state;
   logic [IDX_W-1:0]     ptr;
   logic [IDX_W-1:0]     gnt_idx;
   logic [IDX_W-1:0]     arb_idx;
   logic [NUM_REQ-1:0]   arb_grant;
   logic                 arb_any;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // Gated by reset so no acceptance can be signalled while the FSM is held.
   assign req_ready     = (state == IDLE && !axi_areset) ? arb_grant : '0;
   assign m_axi.awprot  = AXI_PROT_DEFAULT;
   assign m_axi.arprot  = AXI_PROT_DEFAULT;

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state         <= IDLE;
         ptr           <= '0;
         gnt_idx       <= '0;
         m_axi.awaddr  <= '0;
         m_axi.awvalid <= 1'b0;
         m_axi.wdata   <= '0;
         m_axi.wstrb   <= '0;
         m_axi.wvalid  <= 1'b0;
         m_axi.bready  <= 1'b0;
         m_axi.araddr  <= '0;
         m_axi.arvalid <= 1'b0;
         m_axi.rready  <= 1'b0;
         rsp_valid     <= '0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
      end else begin
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (arb_any) begin
                  gnt_idx <= arb_idx;
                  ptr     <= IDX_W'(rr_next(int'(arb_idx), NUM_REQ));
                  if (req_we[arb_idx]) begin
                     m_axi.awaddr  <= req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                     m_axi.wdata   <= req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                     m_axi.wstrb   <= req_wstrb[int'(arb_idx)*STRB +: STRB];
                     m_axi.awvalid <= 1'b1;
                     m_axi.wvalid  <= 1'b1;
                     state         <= WR_REQ;
                  end else begin
                     m_axi.araddr  <= req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                     m_axi.arvalid <= 1'b1;
                     state         <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               // AW and W complete independently; move on once neither is pending.
               if (m_axi.awready) m_axi.awvalid <= 1'b0;
               if (m_axi.wready)  m_axi.wvalid  <= 1'b0;
               if ((!m_axi.awvalid || m_axi.awready) && (!m_axi.wvalid || m_axi.wready)) begin
                  m_axi.bready <= 1'b1;
                  state        <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (m_axi.bvalid) begin
                  m_axi.bready       <= 1'b0;
                  rsp_valid[gnt_idx] <= 1'b1;
                  rsp_err            <= (m_axi.bresp != AXI_RESP_OKAY);
                  state              <= IDLE;
               end
            end
            RD_REQ: begin
               if (m_axi.arready) begin
                  m_axi.arvalid <= 1'b0;
                  m_axi.rready  <= 1'b1;
                  state         <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (m_axi.rvalid) begin
                  m_axi.rready       <= 1'b0;
                  rsp_rdata          <= m_axi.rdata;
                  rsp_err            <= (m_axi.rresp != AXI_RESP_OKAY);
                  rsp_valid[gnt_idx] <= 1'b1;
                  state              <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ARB_PERF_EN
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         perf_grants <= '0;
         perf_wait   <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && (perf_grants[i*32 +: 32] != 32'hFFFF_FFFF))
               perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32] + 32'd1;
            if (req_valid[i] && !req_ready[i] && (perf_wait[i*32 +: 32] != 32'hFFFF_FFFF))
               perf_wait[i*32 +: 32] <= perf_wait[i*32 +: 32] + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ram_axi_arbiter.sv
// Bench for ram_axi_arbiter: AXI4-Lite RAM model with stall/error knobs plus a response scoreboard.
module tb_ram_axi_arbiter;

   logic        axi_aclk = 1'b0;
   logic        axi_areset;
   logic [1:0]  req_valid;
   logic [1:0]  req_we;
   logic [19:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
`ifdef ARB_PERF_EN
   logic [63:0] perf_grants;
   logic [63:0] perf_wait;
`endif

   ram_axi_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

   ram_axi_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_REQ(2)) dut (
      .axi_aclk    (axi_aclk),
      .axi_areset  (axi_areset),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_wstrb   (req_wstrb),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
`ifdef ARB_PERF_EN
      .perf_grants (perf_grants),
      .perf_wait   (perf_wait),
`endif
      .m_axi       (bus)
   );

   initial forever #5 axi_aclk = ~axi_aclk;

   typedef struct {
      int          idx;
      logic [31:0] rdata;
      logic        err;
      bit          chk_rd;
   } exp_t;

   exp_t sb[$];
   int   gnt_log[$];
   int   checks  = 0;
   int   errors  = 0;
   int   rsp_cnt = 0;

   // ---------------- RAM slave model ----------------
   logic [31:0] mem [1024];
   logic        aw_have, w_have;
   logic [9:0]  aw_a;
   logic [31:0] w_d;
   logic [3:0]  w_s;
   int          w_wait;
   int          w_stall;
   int          b_hs = 0;
   bit          b_block;
   logic [1:0]  rresp_cfg, bresp_cfg;

   function automatic logic [31:0] init_val(input int a);
      if (a == 5) return 32'hDEAD_BEEF;
      if (a == 3) return 32'hFFFF_FFFF;
      return 32'hA500_0000 | 32'(a);
   endfunction

   assign bus.awready = !aw_have;
   assign bus.wready  = !w_have && (w_wait >= w_stall);

   always @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         for (int a = 0; a < 1024; a++) mem[a] <= init_val(a);
         aw_have     <= 1'b0;
         w_have      <= 1'b0;
         aw_a        <= '0;
         w_d         <= '0;
         w_s         <= '0;
         w_wait      <= 0;
         bus.bvalid  <= 1'b0;
         bus.bresp   <= 2'b00;
         bus.arready <= 1'b0;
         bus.rvalid  <= 1'b0;
         bus.rdata   <= '0;
         bus.rresp   <= 2'b00;
      end else begin
         if (bus.awvalid && bus.awready) begin
            aw_have <= 1'b1;
            aw_a    <= bus.awaddr;
         end
         if (bus.wvalid && bus.wready) begin
            w_have <= 1'b1;
            w_d    <= bus.wdata;
            w_s    <= bus.wstrb;
            w_wait <= 0;
         end else if (bus.wvalid && !w_have) begin
            w_wait <= w_wait + 1;
         end
         if (aw_have && w_have && !bus.bvalid && !b_block) begin
            for (int b = 0; b < 4; b++)
               if (w_s[b]) mem[aw_a][8*b +: 8] <= w_d[8*b +: 8];
            bus.bvalid <= 1'b1;
            bus.bresp  <= bresp_cfg;
            aw_have    <= 1'b0;
            w_have     <= 1'b0;
         end
         if (bus.bvalid && bus.bready) begin
            bus.bvalid <= 1'b0;
            b_hs       <= b_hs + 1;
         end
         bus.arready <= bus.arvalid && !bus.arready && !bus.rvalid;
         if (bus.arvalid && bus.arready) begin
            bus.rvalid <= 1'b1;
            bus.rdata  <= mem[bus.araddr];
            bus.rresp  <= rresp_cfg;
         end
         if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      end
   end

   // ---------------- response scoreboard ----------------
   always @(negedge axi_aclk) begin : monitor
      exp_t       e;
      logic [1:0] exp_oh;
      if (!axi_areset && rsp_valid != 2'b00) begin
         rsp_cnt++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected got rsp_valid=%b expected no response", rsp_valid);
         end else begin
            e      = sb.pop_front();
            exp_oh = 2'b01 << e.idx;
            if (rsp_valid !== exp_oh || rsp_err !== e.err || (e.chk_rd && rsp_rdata !== e.rdata)) begin
               errors++;
               $display("FAIL rsp_check got valid=%b rdata=%h err=%b expected valid=%b rdata=%h err=%b",
                        rsp_valid, rsp_rdata, rsp_err, exp_oh, e.rdata, e.err);
            end
         end
      end
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic drive_req(input int i, input bit we, input logic [9:0] a,
                            input logic [31:0] d, input logic [3:0] s);
      req_we[i]             = we;
      req_addr[i*10 +: 10]  = a;
      req_wdata[i*32 +: 32] = d;
      req_wstrb[i*4 +: 4]   = s;
      req_valid[i]          = 1'b1;
   endtask

   task automatic push_exp(input int i, input logic [31:0] rd, input logic err, input bit chk);
      exp_t e;
      e.idx = i; e.rdata = rd; e.err = err; e.chk_rd = chk;
      sb.push_back(e);
      gnt_log.push_back(i);
   endtask

   task automatic issue(input int i, input bit we, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] rd, input logic err, input bit chk);
      bit got;
      got = 1'b0;
      drive_req(i, we, a, d, s);
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge axi_aclk);
         if (req_ready[i]) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL grant_timeout req%0d got no req_ready in 200 cycles expected a grant", i);
      end else begin
         push_exp(i, rd, err, chk);
      end
      @(posedge axi_aclk); #1;
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_drain(output bit ok);
      for (int c = 0; c < 300 && sb.size() != 0; c++) @(negedge axi_aclk);
      ok = (sb.size() == 0);
      @(posedge axi_aclk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(posedge axi_aclk);
      @(negedge axi_aclk);
      checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL reset_req_rsp got ready=%b rsp=%b expected 00/00", req_ready, rsp_valid);
      end
      checks++;
      if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_rdata got %h err=%b expected 0/0", rsp_rdata, rsp_err);
      end
      checks++;
      if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
         errors++;
         $display("FAIL reset_axi_handshake got %b expected 00000",
                  {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
      end
      checks++;
      if (bus.awaddr !== 10'h0 || bus.araddr !== 10'h0 || bus.wdata !== 32'h0 || bus.wstrb !== 4'h0
          || bus.awprot !== 3'b000 || bus.arprot !== 3'b000) begin
         errors++;
         $display("FAIL reset_axi_payload got aw=%h ar=%h wd=%h ws=%h expected all 0",
                  bus.awaddr, bus.araddr, bus.wdata, bus.wstrb);
      end
      @(posedge axi_aclk); #1;
      axi_areset = 1'b0;
   endtask

   task automatic test_single_read();
      bit got;
      int lat;
      got = 1'b0;
      lat = -1;
      drive_req(0, 1'b0, 10'd5, 32'h0, 4'h0);
      for (int c = 0; c < 50 && !got; c++) begin
         @(negedge axi_aclk);
         if (req_ready != 2'b00) got = 1'b1;
      end
      checks++;
      if (!got || req_ready !== 2'b01) begin
         errors++;
         $display("FAIL read_grant got ready=%b expected 01", req_ready);
      end
      push_exp(0, 32'hDEAD_BEEF, 1'b0, 1'b1);
      @(posedge axi_aclk); #1;
      req_valid[0] = 1'b0;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
         @(negedge axi_aclk);
         if (k == 1) begin
            checks++;
            if (bus.arvalid !== 1'b1 || bus.araddr !== 10'd5) begin
               errors++;
               $display("FAIL read_arvalid got arvalid=%b araddr=%h expected 1/005", bus.arvalid, bus.araddr);
            end
         end
         if (rsp_valid[0]) lat = k;
      end
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL read_latency got %0d expected 4", lat);
      end
      @(posedge axi_aclk); #1;
   endtask

   task automatic test_partial_write();
      bit ok;
      issue(1, 1'b1, 10'd3, 32'h1122_3344, 4'b0011, 32'h0, 1'b0, 1'b0);
      issue(1, 1'b0, 10'd3, 32'h0, 4'h0, 32'hFFFF_3344, 1'b0, 1'b1);
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL partial_write_drain got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic test_error_resp();
      bit ok;
      rresp_cfg = 2'b10;
      issue(0, 1'b0, 10'd7, 32'h0, 4'h0, init_val(7), 1'b1, 1'b1);
      wait_drain(ok);
      rresp_cfg = 2'b00;
      bresp_cfg = 2'b10;
      issue(1, 1'b1, 10'd8, 32'h5555_AAAA, 4'hF, 32'h0, 1'b1, 1'b0);
      wait_drain(ok);
      bresp_cfg = 2'b00;
      issue(1, 1'b0, 10'd9, 32'h0, 4'h0, init_val(9), 1'b0, 1'b1);
      issue(0, 1'b0, 10'd8, 32'h0, 4'h0, 32'h5555_AAAA, 1'b0, 1'b1);
      issue(1, 1'b0, 10'd9, 32'h0, 4'h0, init_val(9), 1'b0, 1'b1);
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL error_drain got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic test_contention();
      bit ok;
      gnt_log.delete();
      fork
         begin
            for (int n = 0; n < 4; n++)
               issue(0, 1'b0, 10'(20 + n), 32'h0, 4'h0, init_val(20 + n), 1'b0, 1'b1);
         end
         begin
            for (int n = 0; n < 4; n++)
               issue(1, 1'b0, 10'(40 + n), 32'h0, 4'h0, init_val(40 + n), 1'b0, 1'b1);
         end
      join
      wait_drain(ok);
      checks++;
      if (!ok || gnt_log.size() != 8) begin
         errors++;
         $display("FAIL contention_count got %0d grants expected 8", gnt_log.size());
      end
      for (int n = 0; n < gnt_log.size(); n++) begin
         checks++;
         if (gnt_log[n] != n % 2) begin
            errors++;
            $display("FAIL contention_order slot %0d got req%0d expected req%0d", n, gnt_log[n], n % 2);
         end
      end
   endtask

   task automatic test_aw_w_skew();
      bit   got, ok;
      logic awv[1:6];
      logic wv[1:6];
      int   b0, r0;
      got     = 1'b0;
      w_stall = 3;
      b0      = b_hs;
      r0      = rsp_cnt;
      drive_req(0, 1'b1, 10'd12, 32'hCAFE_F00D, 4'hF);
      for (int c = 0; c < 50 && !got; c++) begin
         @(negedge axi_aclk);
         if (req_ready[0]) got = 1'b1;
      end
      push_exp(0, 32'h0, 1'b0, 1'b0);
      @(posedge axi_aclk); #1;
      req_valid[0] = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge axi_aclk);
         awv[k] = bus.awvalid;
         wv[k]  = bus.wvalid;
      end
      checks++;
      if (!got || awv[1] !== 1'b1 || wv[1] !== 1'b1 || awv[2] !== 1'b0) begin
         errors++;
         $display("FAIL skew_aw got aw=%b%b w1=%b expected aw=10 w1=1", awv[1], awv[2], wv[1]);
      end
      checks++;
      if (wv[2] !== 1'b1 || wv[3] !== 1'b1 || wv[4] !== 1'b1 || wv[5] !== 1'b0) begin
         errors++;
         $display("FAIL skew_w got w2..5=%b%b%b%b expected 1110", wv[2], wv[3], wv[4], wv[5]);
      end
      wait_drain(ok);
      w_stall = 0;
      checks++;
      if (!ok || b_hs - b0 != 1 || rsp_cnt - r0 != 1) begin
         errors++;
         $display("FAIL skew_counts got b=%0d rsp=%0d expected 1/1", b_hs - b0, rsp_cnt - r0);
      end
      issue(1, 1'b0, 10'd12, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
      wait_drain(ok);
   endtask

   task automatic test_reset_mid_write();
      bit got, ok;
      int r0;
      got     = 1'b0;
      b_block = 1'b1;
      issue(0, 1'b1, 10'd9, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 1'b0);
      r0 = rsp_cnt;
      for (int c = 0; c < 50 && !got; c++) begin
         @(negedge axi_aclk);
         if (bus.bready === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL midwr_bready got bready=%b expected 1", bus.bready);
      end
      axi_areset = 1'b1;
      drive_req(1, 1'b0, 10'd11, 32'h0, 4'h0);
      #1;
      checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00 ||
          {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
         errors++;
         $display("FAIL midwr_reset_ctl got ready=%b rsp=%b axi=%b expected 00 00 00000", req_ready, rsp_valid,
                  {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
      end
      checks++;
      if (bus.awaddr !== 10'h0 || bus.wdata !== 32'h0 || bus.wstrb !== 4'h0) begin
         errors++;
         $display("FAIL midwr_reset_data got aw=%h wd=%h ws=%h expected 0", bus.awaddr, bus.wdata, bus.wstrb);
      end
      sb.delete();
      @(posedge axi_aclk); #1;
      axi_areset = 1'b0;
      b_block    = 1'b0;
      drive_req(0, 1'b0, 10'd10, 32'h0, 4'h0);
      @(negedge axi_aclk);
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL midwr_tie got ready=%b expected 01", req_ready);
      end
      if (req_ready[0]) push_exp(0, init_val(10), 1'b0, 1'b1);
      @(posedge axi_aclk); #1;
      req_valid[0] = 1'b0;
      issue(1, 1'b0, 10'd11, 32'h0, 4'h0, init_val(11), 1'b0, 1'b1);
      wait_drain(ok);
      checks++;
      if (!ok || rsp_cnt - r0 != 2) begin
         errors++;
         $display("FAIL midwr_rsp_count got %0d expected 2", rsp_cnt - r0);
      end
   endtask

   initial begin
      axi_areset = 1'b1;
      req_valid  = '0;
      req_we     = '0;
      req_addr   = '0;
      req_wdata  = '0;
      req_wstrb  = '0;
      b_block    = 1'b0;
      w_stall    = 0;
      rresp_cfg  = 2'b00;
      bresp_cfg  = 2'b00;
      test_reset();
      test_single_read();
      test_partial_write();
      test_error_resp();
      test_contention();
      test_aw_w_skew();
      test_reset_mid_write();
      repeat (5) @(posedge axi_aclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no completion expected finish before 500000");
      $fatal(1);
   end

endmodule

// File: doc/ram_axi_arbiter.md
# ram_axi_arbiter

Shares the single AXI4-Lite RAM slave between NUM_REQ simple valid/ready requesters, e.g. instruction fetch (req 0) and load/store (req 1) of the core. The block round-robins between requesters, converts each granted request into one AXI4-Lite read or write, and returns a one-cycle response pulse to the winner. It keeps exactly one transaction outstanding and sits between the core's memory ports and the RAM.

## Interface
- ADDR_WIDTH, 10, AXI word address width; matches RAM.
- DATA_WIDTH, 32, data width; STRB = DATA_WIDTH/8.
- NUM_REQ, 2, number of requesters, ≥2.
- axi_aclk  in  1  single clock; all logic on rising edge.
- axi_areset  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ×ADDR_WIDTH  packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ×DATA_WIDTH  packed write data.
- req_wstrb  in  NUM_REQ×STRB  packed byte strobes.
- req_ready  out  NUM_REQ  one-hot acceptance pulse.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  1 when BRESP/RRESP ≠ OKAY, valid with rsp_valid.
- m_axi_aw{addr,prot,valid} out / m_axi_awready in: write address channel; awprot = 3'b000.
- m_axi_w{data,strb,valid} out / m_axi_wready in: write data channel.
- m_axi_b{resp,valid} in / m_axi_bready out: write response.
- m_axi_ar{addr,prot,valid} out / m_axi_arready in: read address; arprot = 3'b000.
- m_axi_r{data,resp,valid} in / m_axi_rready out: read data.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE: if any req_valid, the round-robin picks winner g; req_ready[g]=1 combinationally this cycle; addr/data/strb/we and g captured; next state WR_REQ (we=1) or RD_REQ.
- Round-robin: pointer p (reset 0); search order p, p+1, … mod NUM_REQ; after grant p ← (g+1) mod NUM_REQ.
- WR_REQ: awvalid and wvalid both high on entry; each drops independently after its own handshake; when both done → WR_RESP.
- WR_RESP: bready=1; on bvalid → rsp_valid[g]=1, rsp_err=(bresp≠0), → IDLE.
- RD_REQ: arvalid=1 until arready → RD_RESP.
- RD_RESP: rready=1; on rvalid → rsp_rdata=rdata, rsp_err=(rresp≠0), rsp_valid[g]=1, → IDLE.
- Requesters hold req_valid and payload stable until req_ready; rsp_valid is not backpressured.
- Addresses and data pass through unmodified.

## Timing
- Reset values: all req_ready/rsp_valid 0, rsp_rdata 0, rsp_err 0, all AXI valid/ready outputs 0, address/data outputs 0, state IDLE, p = 0.
- AXI valid/ready outputs and rsp_* are registered; req_ready is combinational from req_valid and state.
- Grant at cycle t; AXI valid at t+1; rsp_valid the cycle after the B/R handshake.
- Read against the RAM: grant t, arvalid t+1, rsp_valid t+4; next grant t+4 at the earliest (IDLE).
- Simultaneous requests: only the pointer-nearest requester is granted; the loser waits ≤ NUM_REQ−1 transactions.
- req_valid arriving outside IDLE is held off (req_ready=0) until the next IDLE.
- Reset mid-transaction: immediate return to IDLE, outstanding AXI transfer abandoned, no rsp_valid; the RAM is reset in the same domain.

## Configuration
- ARB_PERF_EN defined: adds outputs perf_grants (NUM_REQ×32, per-requester grant count) and perf_wait (NUM_REQ×32, cycles with req_valid=1 and req_ready=0); counters saturate at 2^32−1 and clear on reset.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Structure
- Package ram_arb_pkg: state enum, AXI_RESP_OKAY = 2'b00, AXI_PROT_DEFAULT = 3'b000.
- Sub-module rr_arbiter (inputs req and pointer; outputs one-hot grant and index); used for the IDLE selection.

## Test plan
- Single read: ram[5]=0xDEADBEEF, req0 read addr 5 -> req_ready[0] at t, rsp_valid[0] at t+4, rdata 0xDEADBEEF, err 0.
- Partial write: req1 write addr 3, data 0x11223344, strb 4'b0011 over 0xFFFFFFFF -> rsp_valid[1]; a later read returns 0xFFFF3344.
- Contention: req0 and req1 both reading continuously -> grants alternate 0,1,0,1; each requester gets exactly its own rdata.
- AW/W skew: stall wready 3 cycles while awready is immediate -> awvalid drops after 1 cycle, wvalid holds; single bvalid; one rsp_valid.
- Error response: slave returns RRESP=2'b10 -> rsp_err=1 with rsp_valid.
- Reset mid-write: assert axi_areset in WR_RESP -> all outputs at reset values the same cycle, no rsp_valid; after release, p=0 and req0 wins a tie.
